// File: rtl/flux_rr_scheduler.sv
// Round-robin flux scheduler with a per-flux burst lock, for FLUX-tagged multi-flux actors.
// Optional macro FLUX_SCHED_BLOCK_LOCK_EN: hold the lock until last[owner] instead of BURST.
module flux_rr_scheduler #(
    parameter  int FLUX      = 2,
    parameter  int BURST     = 4,
    localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1,
    localparam int CNT_WIDTH = $clog2(BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLUX-1:0]      req,
    input  logic [FLUX-1:0]      last,
    input  logic                 fire,
    output logic [FLUX-1:0]      grant,
    output logic [TAG_WIDTH-1:0] tag,
    output logic                 valid,
    output logic                 locked
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t               st, st_d;
    logic [TAG_WIDTH-1:0] owner, owner_d;
    logic [TAG_WIDTH-1:0] ptr, ptr_d;
    logic [CNT_WIDTH-1:0] cnt, cnt_d;

    logic [TAG_WIDTH-1:0] win;
    logic                 found;
    logic [TAG_WIDTH-1:0] tag_int;
    logic                 valid_int;
    logic                 release_cond;
    int                   idx;

    function automatic logic [TAG_WIDTH-1:0] next_index(input logic [TAG_WIDTH-1:0] v);
        if (int'(v) >= FLUX - 1) return '0;
        return v + TAG_WIDTH'(1);
    endfunction

    // Walk from the highest offset down so the request nearest ptr is written last and wins.
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= FLUX) idx = idx - FLUX;
            if (req[idx]) begin
                win   = TAG_WIDTH'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        valid_int = 1'b0;
        tag_int   = '0;
        if (st == ST_IDLE) begin
            valid_int = found;
            tag_int   = found ? win : '0;
        end else begin
            valid_int = req[owner];
            tag_int   = req[owner] ? owner : '0;
        end
    end

    // Outputs are gated by rst so they drop immediately on an asynchronous assertion.
    assign valid  = rst & valid_int;
    assign tag    = rst ? tag_int : '0;
    assign grant  = valid ? (FLUX'(1) << tag_int) : '0;
    assign locked = rst & (st == ST_LOCKED);

`ifdef FLUX_SCHED_BLOCK_LOCK_EN
    assign release_cond = last[owner];
`else
    assign release_cond = last[owner] || (cnt == CNT_WIDTH'(BURST - 1));
`endif

    always_comb begin
        st_d    = st;
        owner_d = owner;
        ptr_d   = ptr;
        cnt_d   = cnt;
        if (st == ST_IDLE) begin
            if (fire && valid_int) begin
                if (BURST == 1 || last[win]) begin
                    ptr_d = next_index(win);
                    cnt_d = '0;
                end else begin
                    st_d    = ST_LOCKED;
                    owner_d = win;
                    cnt_d   = CNT_WIDTH'(1);
                end
            end
        end else begin
            // A dropped owner request costs one bubble cycle, then the lock is released.
            if (!req[owner] || (fire && release_cond)) begin
                st_d  = ST_IDLE;
                ptr_d = next_index(owner);
                cnt_d = '0;
            end else if (fire) begin
`ifdef FLUX_SCHED_BLOCK_LOCK_EN
                cnt_d = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
`else
                cnt_d = cnt + CNT_WIDTH'(1);
`endif
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st    <= ST_IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            st    <= st_d;
            owner <= owner_d;
            ptr   <= ptr_d;
            cnt   <= cnt_d;
        end
    end

    a_fire_needs_valid: assert property (@(posedge clk) disable iff (!rst) fire |-> valid);
    a_grant_onehot:     assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));

endmodule
